// File: rtl/wshb_mire_writer_if.sv
// Wishbone bus bundle between the mire writer (master) and the interconnect
// mire slave port (slave). dat_ms travels master->slave, dat_sm slave->master.
interface wshb_mire_writer_if;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat_ms;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic [31:0] dat_sm;
    logic        rty;
    logic        err;

    modport master (
        output cyc, stb, adr, we, dat_ms, sel, cti, bte,
        input  ack, dat_sm, rty, err
    );

    modport slave (
        input  cyc, stb, adr, we, dat_ms, sel, cti, bte,
        output ack, dat_sm, rty, err
    );
endinterface

// File: rtl/wshb_mire_writer.sv
// Wishbone master that paints a scrolling test pattern into the SDRAM
// framebuffer, one 32-bit pixel per classic write cycle. It gives the bus up
// for RELEASE_CYC cycles after every BURST_LEN pixels so the VGA reader can
// be granted the SDRAM.
module wshb_mire_writer #(
    parameter int HDISP       = 800,
    parameter int VDISP       = 480,
    parameter int BURST_LEN   = 64,
    parameter int RELEASE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    wshb_mire_writer_if.master    wb,
    output logic                  frame_done
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int RW = $clog2(RELEASE_CYC + 1);

    typedef enum logic [1:0] {IDLE, WRITE, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [15:0]   x, y, x_nxt, y_nxt;
    logic [7:0]    frame, frame_nxt;
    logic [BW-1:0] burst_cnt;
    logic [RW-1:0] rel_cnt;
    logic          accept, x_last, y_last, frame_wrap, grid;
    logic [31:0]   pix_nxt;
    logic          unused_dat;

    // Read data is meaningless for a write-only master.
    assign unused_dat = ^wb.dat_sm;

    assign wb.we  = 1'b1;
    assign wb.sel = 4'hF;
    assign wb.cti = 3'b000;
    assign wb.bte = 2'b00;

    // Next pixel position and its colour; ack beats err when both are high.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        accept     = (state == WRITE) && wb.ack;
        x_last     = (x == 16'(HDISP - 1));
        y_last     = (y == 16'(VDISP - 1));
        frame_wrap = x_last && y_last;
        x_nxt      = x_last ? 16'd0 : x + 16'd1;
        y_nxt      = y;
        frame_nxt  = frame;
        if (x_last)
            y_nxt = y_last ? 16'd0 : y + 16'd1;
        if (frame_wrap)
            frame_nxt = frame + 8'd1;
        grid    = (x_nxt[3:0] == 4'd0) || (y_nxt[3:0] == 4'd0);
        pix_nxt = grid ? 32'h00FF_FFFF
                       : {8'h00, x_nxt[7:0] + frame_nxt, y_nxt[7:0], frame_nxt};
    end

    // Next-state logic: burst end, error or a disable request end the tenure.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en)
                    state_nxt = WRITE;
            end
            WRITE: begin
                if (wb.ack) begin
                    if ((burst_cnt == BW'(BURST_LEN - 1)) || !en)
                        state_nxt = RELEASE;
                end else if (wb.err) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (rel_cnt == RW'(RELEASE_CYC - 1))
                    state_nxt = en ? WRITE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Registered bus outputs, pixel counters and tenure counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.cyc     <= 1'b0;
            wb.stb     <= 1'b0;
            wb.adr     <= 32'd0;
            wb.dat_ms  <= 32'h00FF_FFFF;
            frame_done <= 1'b0;
            x          <= 16'd0;
            y          <= 16'd0;
            frame      <= 8'd0;
            burst_cnt  <= '0;
            rel_cnt    <= '0;
        end else begin
            wb.cyc     <= (state_nxt == WRITE);
            wb.stb     <= (state_nxt == WRITE);
            frame_done <= accept && frame_wrap;
            if (accept) begin
                x         <= x_nxt;
                y         <= y_nxt;
                frame     <= frame_nxt;
                // Pixels are written in raster order, so the address simply
                // steps by one word and returns to 0 at the frame wrap.
                wb.adr    <= frame_wrap ? 32'd0 : wb.adr + 32'd4;
                wb.dat_ms <= pix_nxt;
                burst_cnt <= burst_cnt + BW'(1);
            end
            if (state == RELEASE) begin
                burst_cnt <= '0;
                rel_cnt   <= rel_cnt + RW'(1);
            end else begin
                rel_cnt   <= '0;
            end
        end
    end

endmodule

// File: doc/wshb_mire_writer.md
# wshb_mire_writer

Wishbone master that fills the SDRAM framebuffer with a test pattern (the "mire"), one 32-bit pixel per transfer. It sits directly upstream of the interconnect, on the mire slave port, sharing the SDRAM with the VGA reader. It drops `cyc` periodically so the interconnect can hand the bus to the VGA reader. It writes frames continuously, and a frame counter makes the pattern scroll.

## Interface
- `HDISP`, 800: active pixels per line.
- `VDISP`, 480: active lines per frame.
- `BURST_LEN`, 64: acknowledged writes per bus tenure before release.
- `RELEASE_CYC`, 2: cycles with `cyc`=0 between tenures; must be ≥1.
- `clk` in 1: system clock, same clock as the SDRAM Wishbone bus.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: pattern generation enable.
- `cyc` out 1: Wishbone cycle.
- `stb` out 1: Wishbone strobe.
- `adr` out 32: byte address.
- `we` out 1: constant 1.
- `dat_ms` out 32: write data.
- `sel` out 4: constant 4'hF.
- `cti` out 3: constant 3'b000 (classic cycles).
- `bte` out 2: constant 2'b00.
- `ack` in 1: slave acknowledge.
- `dat_sm` in 32: ignored.
- `rty` in 1: slave retry.
- `err` in 1: slave error.
- `frame_done` out 1: one-cycle pulse when the last pixel of a frame is acknowledged.

## Operation
- Pixel position:
  - Counters `x` (0..HDISP-1) and `y` (0..VDISP-1).
  - Frame counter `frame` is 8 bits and wraps 255→0.
- Address: `adr` = 4·(y·HDISP + x), computed on 32 bits with no truncation.
- Data: `dat_ms` = {8'h00, R, G, B}.
  - Grid pixels are white (24'hFFFFFF) when x[3:0]==0 or y[3:0]==0.
  - All other pixels use R = x[7:0]+frame, G = y[7:0], B = frame.
- FSM has three states: IDLE, WRITE, RELEASE.
  - IDLE: `cyc`=`stb`=0. Moves to WRITE when `en`=1.
  - WRITE: `cyc`=`stb`=1. On each clock edge with `ack`=1:
    - advance x;
    - at x wrap, advance y;
    - at y wrap, advance `frame` and pulse `frame_done`;
    - increment the burst counter.
  - WRITE → RELEASE when:
    - the BURST_LEN-th ack arrives; or
    - `err`=1, in which case the pixel is not advanced and is rewritten in the next tenure; or
    - an ack arrives while `en`=0.
  - `rty`=1 without `ack`: the transfer stays pending and the state is unchanged.
  - RELEASE: `cyc`=`stb`=0 for RELEASE_CYC cycles. The burst counter clears. Then go to WRITE if `en`=1, otherwise IDLE.
- `en` deasserted mid-transfer: the pending strobe is never withdrawn; the block waits for `ack` or `err`.
- `adr`/`dat_ms` stay stable while `stb`=1 and no ack has been seen.
- If `ack` and `err` are both 1, `ack` wins.

## Timing
- All outputs are registered.
- Reset values: `cyc`=0, `stb`=0, `adr`=0, `dat_ms`=32'h00FFFFFF (pixel 0,0 is grid), `frame_done`=0; x=y=frame=0; state IDLE. Constant outputs are 1/4'hF/0/0 at all times.
- Startup: with `en`=1 at the first edge after `rst_n` rises, `cyc`/`stb` go high after that edge, which is 1 cycle of latency.
- Throughput: with `ack` tied high, one pixel per cycle. `adr`/`dat_ms` update on the same edge that samples `ack`.
- Bus release: after the BURST_LEN-th ack, `cyc` is low for exactly RELEASE_CYC cycles, then high again (with `en`=1 and no arbitration delay). At least one edge always sees `cyc`=0, which the interconnect needs to swap ownership.
- Reset mid-operation: `rst_n` low forces reset values immediately, asynchronously. The frame restarts at pixel (0,0), frame 0.
- `frame_done` is high in the cycle after the edge that accepted pixel (HDISP-1, VDISP-1).

## Test plan
- **Reset:** assert `rst_n`=0 mid-burst → `cyc`/`stb` drop immediately and `adr`=0. After release with `en`=1, the first write has `adr`=0 and `dat_ms`=32'h00FFFFFF.
- **Burst/release:** `ack` always 1, BURST_LEN=64, RELEASE_CYC=2 → 64 consecutive writes at `adr` 0..252, then `cyc`=0 for 2 cycles, then the next write at `adr`=256 (x=64).
- **Pattern/line wrap:**
  - x=17,y=1,frame=0 → `dat_ms`=32'h00110100.
  - Pixel (799,0) at `adr`=3196 is followed by (0,1) at `adr`=3200.
- **Frame wrap:** HDISP=8, VDISP=4 → `frame_done` pulses after the 32nd ack, and pixel (1,1) of frame 1 carries B=8'h01.
- **Wait states, rty, err:**
  - `ack` delayed 3 cycles with `rty` pulses → `adr`/`dat_ms` are stable throughout.
  - `err` on x=5 → `cyc` drops for RELEASE_CYC cycles, then x=5 is rewritten.
- **Enable:** `en`=0 while `stb` is pending → the write completes on `ack`, then the block releases and parks in IDLE with `cyc`=0. Re-asserting `en` resumes at the next pixel.
